// File: rtl/hack_keyboard_pkg.sv
// Shared constants and types for the MiSTer PS/2 to Hack KBD translator.
package hack_kbd_pkg;

    // Hack special key codes (non-printable keys live above 127)
    localparam logic [7:0] HK_NEWLINE   = 8'd128;
    localparam logic [7:0] HK_BACKSPACE = 8'd129;
    localparam logic [7:0] HK_LEFT      = 8'd130;
    localparam logic [7:0] HK_UP        = 8'd131;
    localparam logic [7:0] HK_RIGHT     = 8'd132;
    localparam logic [7:0] HK_DOWN      = 8'd133;
    localparam logic [7:0] HK_HOME      = 8'd134;
    localparam logic [7:0] HK_END       = 8'd135;
    localparam logic [7:0] HK_PGUP      = 8'd136;
    localparam logic [7:0] HK_PGDN      = 8'd137;
    localparam logic [7:0] HK_INSERT    = 8'd138;
    localparam logic [7:0] HK_DELETE    = 8'd139;
    localparam logic [7:0] HK_ESC       = 8'd140;
    localparam logic [7:0] HK_F1        = 8'd141;
    localparam logic [7:0] HK_F2        = 8'd142;
    localparam logic [7:0] HK_F3        = 8'd143;
    localparam logic [7:0] HK_F4        = 8'd144;
    localparam logic [7:0] HK_F5        = 8'd145;
    localparam logic [7:0] HK_F6        = 8'd146;
    localparam logic [7:0] HK_F7        = 8'd147;
    localparam logic [7:0] HK_F8        = 8'd148;
    localparam logic [7:0] HK_F9        = 8'd149;
    localparam logic [7:0] HK_F10       = 8'd150;
    localparam logic [7:0] HK_F11       = 8'd151;
    localparam logic [7:0] HK_F12       = 8'd152;

    // PS/2 set-2 shift scancodes (non-extended)
    localparam logic [7:0] SC_LSHIFT = 8'h12;
    localparam logic [7:0] SC_RSHIFT = 8'h59;

    // One decoded hps_io key event
    typedef struct packed {
        logic       press;
        logic       ext;
        logic [7:0] code;
    } ps2_ev_t;

endpackage

// File: rtl/hack_keyboard_if.sv
// Key event input and Hack KBD output bundle between hps_io side and core side.
interface hack_keyboard_if;
    logic [10:0] ps2_key;
    logic [15:0] kbd;
    logic        kbd_changed;

    modport master (output ps2_key, input kbd, input kbd_changed);
    modport slave  (input ps2_key, output kbd, output kbd_changed);
endinterface

// File: rtl/hack_keyboard_lut.sv
// Combinational PS/2 set-2 scancode to Hack character code table.
module hack_scancode_lut
    import hack_kbd_pkg::*;
(
    input  logic       ext,
    input  logic [7:0] code,
    input  logic       shift,
    output logic [7:0] hack_code,
    output logic       mapped
);

    function automatic logic [7:0] pick(input logic sh, input logic [7:0] lo, input logic [7:0] hi);
        return sh ? hi : lo;
    endfunction

    // Full lookup; extended and plain scancodes are separate tables
    always_comb begin
        hack_code = 8'd0;
        mapped    = 1'b1;
        if (ext) begin
            case (code)
                8'h5A:   hack_code = HK_NEWLINE;
                8'h6B:   hack_code = HK_LEFT;
                8'h75:   hack_code = HK_UP;
                8'h74:   hack_code = HK_RIGHT;
                8'h72:   hack_code = HK_DOWN;
                8'h6C:   hack_code = HK_HOME;
                8'h69:   hack_code = HK_END;
                8'h7D:   hack_code = HK_PGUP;
                8'h7A:   hack_code = HK_PGDN;
                8'h70:   hack_code = HK_INSERT;
                8'h71:   hack_code = HK_DELETE;
                default: mapped    = 1'b0;
            endcase
        end else begin
            case (code)
                // letters
                8'h1C: hack_code = pick(shift, 8'd97,  8'd65);
                8'h32: hack_code = pick(shift, 8'd98,  8'd66);
                8'h21: hack_code = pick(shift, 8'd99,  8'd67);
                8'h23: hack_code = pick(shift, 8'd100, 8'd68);
                8'h24: hack_code = pick(shift, 8'd101, 8'd69);
                8'h2B: hack_code = pick(shift, 8'd102, 8'd70);
                8'h34: hack_code = pick(shift, 8'd103, 8'd71);
                8'h33: hack_code = pick(shift, 8'd104, 8'd72);
                8'h43: hack_code = pick(shift, 8'd105, 8'd73);
                8'h3B: hack_code = pick(shift, 8'd106, 8'd74);
                8'h42: hack_code = pick(shift, 8'd107, 8'd75);
                8'h4B: hack_code = pick(shift, 8'd108, 8'd76);
                8'h3A: hack_code = pick(shift, 8'd109, 8'd77);
                8'h31: hack_code = pick(shift, 8'd110, 8'd78);
                8'h44: hack_code = pick(shift, 8'd111, 8'd79);
                8'h4D: hack_code = pick(shift, 8'd112, 8'd80);
                8'h15: hack_code = pick(shift, 8'd113, 8'd81);
                8'h2D: hack_code = pick(shift, 8'd114, 8'd82);
                8'h1B: hack_code = pick(shift, 8'd115, 8'd83);
                8'h2C: hack_code = pick(shift, 8'd116, 8'd84);
                8'h3C: hack_code = pick(shift, 8'd117, 8'd85);
                8'h2A: hack_code = pick(shift, 8'd118, 8'd86);
                8'h1D: hack_code = pick(shift, 8'd119, 8'd87);
                8'h22: hack_code = pick(shift, 8'd120, 8'd88);
                8'h35: hack_code = pick(shift, 8'd121, 8'd89);
                8'h1A: hack_code = pick(shift, 8'd122, 8'd90);
                // digit row with US shifted symbols
                8'h16: hack_code = pick(shift, 8'd49, 8'd33);
                8'h1E: hack_code = pick(shift, 8'd50, 8'd64);
                8'h26: hack_code = pick(shift, 8'd51, 8'd35);
                8'h25: hack_code = pick(shift, 8'd52, 8'd36);
                8'h2E: hack_code = pick(shift, 8'd53, 8'd37);
                8'h36: hack_code = pick(shift, 8'd54, 8'd94);
                8'h3D: hack_code = pick(shift, 8'd55, 8'd38);
                8'h3E: hack_code = pick(shift, 8'd56, 8'd42);
                8'h46: hack_code = pick(shift, 8'd57, 8'd40);
                8'h45: hack_code = pick(shift, 8'd48, 8'd41);
                // space and punctuation
                8'h29: hack_code = 8'd32;
                8'h4E: hack_code = pick(shift, 8'd45, 8'd95);
                8'h55: hack_code = pick(shift, 8'd61, 8'd43);
                8'h54: hack_code = pick(shift, 8'd91, 8'd123);
                8'h5B: hack_code = pick(shift, 8'd93, 8'd125);
                8'h4C: hack_code = pick(shift, 8'd59, 8'd58);
                8'h52: hack_code = pick(shift, 8'd39, 8'd34);
                8'h41: hack_code = pick(shift, 8'd44, 8'd60);
                8'h49: hack_code = pick(shift, 8'd46, 8'd62);
                8'h4A: hack_code = pick(shift, 8'd47, 8'd63);
                8'h5D: hack_code = pick(shift, 8'd92, 8'd124);
                8'h0E: hack_code = pick(shift, 8'd96, 8'd126);
                // control and function keys
                8'h5A: hack_code = HK_NEWLINE;
                8'h66: hack_code = HK_BACKSPACE;
                8'h76: hack_code = HK_ESC;
                8'h05: hack_code = HK_F1;
                8'h06: hack_code = HK_F2;
                8'h04: hack_code = HK_F3;
                8'h0C: hack_code = HK_F4;
                8'h03: hack_code = HK_F5;
                8'h0B: hack_code = HK_F6;
                8'h83: hack_code = HK_F7;
                8'h0A: hack_code = HK_F8;
                8'h01: hack_code = HK_F9;
                8'h09: hack_code = HK_F10;
                8'h78: hack_code = HK_F11;
                8'h07: hack_code = HK_F12;
                default: mapped = 1'b0;
            endcase
        end
    end

endmodule

// File: rtl/hack_keyboard.sv
// hps_io ps2_key events to Hack KBD register: toggle detect, event latch, decode/update.
module hack_keyboard
    import hack_kbd_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    hack_keyboard_if.slave   bus
);

    logic        tgl_q;
    logic        ev_vld;
    ps2_ev_t     ev_data;
    logic        shift_l;
    logic        shift_r;
    logic        held_vld;
    logic [8:0]  held;
    logic [15:0] kbd_q;
    logic        kbd_changed_q;
    logic [7:0]  lut_code;
    logic        lut_mapped;
    logic        event_det;
    logic [15:0] lut_kbd;

    assign event_det = bus.ps2_key[10] ^ tgl_q;
    assign lut_kbd   = {8'h00, lut_code};

    hack_scancode_lut u_lut (
        .ext       (ev_data.ext),
        .code      (ev_data.code),
        .shift     (shift_l | shift_r),
        .hack_code (lut_code),
        .mapped    (lut_mapped)
    );

    // Stage 1: latch the event fields once per toggle flip
    always_ff @(posedge clk) begin
        if (event_det) begin
            ev_data <= '{press: bus.ps2_key[9], ext: bus.ps2_key[8], code: bus.ps2_key[7:0]};
        end
    end

    // Control: toggle tracking, event valid, shift/held state, KBD value and change pulse
    always_ff @(posedge clk) begin
        if (reset) begin
            tgl_q         <= bus.ps2_key[10];
            ev_vld        <= 1'b0;
            shift_l       <= 1'b0;
            shift_r       <= 1'b0;
            held_vld      <= 1'b0;
            kbd_q         <= 16'd0;
            kbd_changed_q <= 1'b0;
        end else begin
            tgl_q         <= bus.ps2_key[10];
            ev_vld        <= event_det;
            kbd_changed_q <= 1'b0;
            // Stage 2: shift keys only move shift state; the held code is fixed at press time
            if (ev_vld) begin
                if (!ev_data.ext && ev_data.code == SC_LSHIFT) begin
                    shift_l <= ev_data.press;
                end else if (!ev_data.ext && ev_data.code == SC_RSHIFT) begin
                    shift_r <= ev_data.press;
                end else if (ev_data.press && lut_mapped) begin
                    kbd_q         <= lut_kbd;
                    held          <= {ev_data.ext, ev_data.code};
                    held_vld      <= 1'b1;
                    kbd_changed_q <= (lut_kbd != kbd_q);
                end else if (!ev_data.press && held_vld && held == {ev_data.ext, ev_data.code}) begin
                    kbd_q         <= 16'd0;
                    held_vld      <= 1'b0;
                    kbd_changed_q <= (kbd_q != 16'd0);
                end
            end
        end
    end

    assign bus.kbd         = kbd_q;
    assign bus.kbd_changed = kbd_changed_q;

endmodule

// File: tb/tb_hack_keyboard.sv
// Directed scoreboard bench for hack_keyboard.
module tb_hack_keyboard;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    logic tgl   = 1'b0;
    int   vectors     = 0;
    int   miscompares = 0;
    logic [15:0] model_kbd = 16'd0;

    typedef struct {
        string       tag;
        logic [15:0] k;
        logic        c;
    } exp_t;
    exp_t sb[$];

    hack_keyboard_if bus ();

    hack_keyboard dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got timeout required completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    // One key event; expected result queued at drive time and checked when it appears
    task automatic ev(input logic press, input logic ext, input logic [7:0] code,
                      input logic [15:0] exp_k, input logic exp_c, input string tag);
        exp_t e;
        @(negedge clk);
        tgl = ~tgl;
        bus.ps2_key = {tgl, press, ext, code};
        sb.push_back('{tag, exp_k, exp_c});
        @(posedge clk); #1;
        chk({tag, " early kbd"}, bus.kbd, model_kbd);
        chk({tag, " early chg"}, {15'd0, bus.kbd_changed}, 16'd0);
        @(posedge clk); #1;
        e = sb.pop_front();
        chk({e.tag, " kbd"}, bus.kbd, e.k);
        chk({e.tag, " chg"}, {15'd0, bus.kbd_changed}, {15'd0, e.c});
        @(posedge clk); #1;
        chk({e.tag, " chg end"}, {15'd0, bus.kbd_changed}, 16'd0);
        chk({e.tag, " kbd hold"}, bus.kbd, e.k);
        model_kbd = e.k;
    endtask

    initial begin
        bus.ps2_key = 11'd0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset kbd", bus.kbd, 16'd0);
        chk("reset chg", {15'd0, bus.kbd_changed}, 16'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("idle kbd", bus.kbd, 16'd0);

        // press/release a
        ev(1, 0, 8'h1C, 16'd97, 1, "press a");
        ev(0, 0, 8'h1C, 16'd0,  1, "release a");

        // shifted digit
        ev(1, 0, 8'h12, 16'd0,  0, "press lshift");
        ev(1, 0, 8'h16, 16'd33, 1, "shift 1");
        ev(0, 0, 8'h12, 16'd33, 0, "release lshift");
        ev(0, 0, 8'h16, 16'd0,  1, "release 1");

        // right shift letter
        ev(1, 0, 8'h59, 16'd0,  0, "press rshift");
        ev(1, 0, 8'h1C, 16'd65, 1, "shift a");
        ev(0, 0, 8'h1C, 16'd0,  1, "release A");
        ev(0, 0, 8'h59, 16'd0,  0, "release rshift");

        // extended vs plain
        ev(1, 1, 8'h6B, 16'd130, 1, "press left");
        ev(1, 0, 8'h6B, 16'd130, 0, "press kp4");
        ev(0, 0, 8'h6B, 16'd130, 0, "release kp4");
        ev(0, 1, 8'h6B, 16'd0,   1, "release left");

        // overlapping keys
        ev(1, 0, 8'h1C, 16'd97, 1, "overlap a");
        ev(1, 0, 8'h32, 16'd98, 1, "overlap b");
        ev(0, 0, 8'h1C, 16'd98, 0, "overlap rel a");
        ev(0, 0, 8'h32, 16'd0,  1, "overlap rel b");

        // typematic and function keys
        ev(1, 0, 8'h83, 16'd147, 1, "press f7");
        ev(1, 0, 8'h83, 16'd147, 0, "repeat f7");
        ev(0, 0, 8'h83, 16'd0,   1, "release f7");
        ev(1, 0, 8'h07, 16'd152, 1, "press f12");
        ev(0, 0, 8'h07, 16'd0,   1, "release f12");
        ev(1, 1, 8'h5A, 16'd128, 1, "press kp enter");
        ev(0, 1, 8'h5A, 16'd0,   1, "release kp enter");

        // shift change while held is ignored until a repeat re-evaluates
        ev(1, 0, 8'h1E, 16'd50, 1, "press 2");
        ev(1, 0, 8'h12, 16'd50, 0, "shift while held");
        ev(1, 0, 8'h1E, 16'd64, 1, "repeat 2 shifted");
        ev(0, 0, 8'h12, 16'd64, 0, "unshift while held");
        ev(0, 0, 8'h1E, 16'd0,  1, "release 2");

        // reset mid-operation
        ev(1, 0, 8'h1A, 16'd122, 1, "press z");
        @(negedge clk);
        tgl = ~tgl;
        bus.ps2_key = {tgl, 1'b0, 1'b0, 8'h1A};
        reset = 1'b1;
        @(posedge clk); #1;
        chk("mid reset kbd", bus.kbd, 16'd0);
        chk("mid reset chg", {15'd0, bus.kbd_changed}, 16'd0);
        @(negedge clk);
        reset = 1'b0;
        model_kbd = 16'd0;
        repeat (3) @(posedge clk);
        #1;
        chk("post reset kbd", bus.kbd, 16'd0);
        chk("post reset chg", {15'd0, bus.kbd_changed}, 16'd0);
        ev(0, 0, 8'h1A, 16'd0,  0, "release z after reset");
        ev(1, 0, 8'h1C, 16'd97, 1, "press a after reset");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
